// File: rtl/cdc_xfer_arbiter.sv
// Round-robin arbiter in front of a clock_a -> clock_b 4-phase req/ack data channel.
// One requester is granted, its word is captured, and xfer_req is raised. The receiver
// samples xfer_data only after it has synchronised xfer_req, so the data bus is never
// synchronised bit by bit. xfer_ack comes back asynchronously and is synchronised here.
module cdc_xfer_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                       clock_a,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic                       xfer_req_o,
  output logic [DATA_W-1:0]          xfer_data_o,
  output logic [$clog2(NUM_REQ)-1:0] xfer_src_o,
  input  logic                       xfer_ack_i,
  output logic                       busy_o,
  output logic                       timeout_err_o,
  input  logic                       err_clr_i
);
  localparam int SRC_W = $clog2(NUM_REQ);
  // A zero TIMEOUT disables the counter; keep it one bit wide so it stays legal.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RELEASE} state_t;

  state_t                         state_q;
  logic [SRC_W-1:0]               ptr_q;
  logic [SYNC_STAGES-1:0]         ack_sync_q;
  logic                           req_q;
  logic [DATA_W-1:0]              data_q;
  logic [SRC_W-1:0]               src_q;
  logic                           err_q;
  logic [CNT_W-1:0]               cnt_q;
  logic [NUM_REQ-1:0][DATA_W-1:0] words;
  logic                           ack_s;
  logic                           grant_any;
  logic [SRC_W-1:0]               grant_idx;
  logic                           to_fire;

  assign words = req_data_i;
  assign ack_s = ack_sync_q[SYNC_STAGES-1];
  assign to_fire = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  // (base + off) modulo NUM_REQ, for off < NUM_REQ.
  function automatic logic [SRC_W-1:0] rr_idx(input logic [SRC_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return SRC_W'(s);
  endfunction

  // Ack synchroniser: raw xfer_ack never reaches the FSM.
  always_ff @(posedge clock_a or negedge rst_n) begin
    if (!rst_n) ack_sync_q <= '0;
    else        ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], xfer_ack_i};
  end

  // Round-robin search from ptr upward with wrap; scanning downward lets the nearest win.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid_i[rr_idx(ptr_q, k)]) begin
        grant_any = 1'b1;
        grant_idx = rr_idx(ptr_q, k);
      end
    end
  end

  // Grant is only offered while idle, so at most one word per handshake.
  always_comb begin
    req_ready_o = '0;
    if (state_q == ST_IDLE && grant_any) req_ready_o = NUM_REQ'(1) << grant_idx;
  end

  // Handshake FSM with capture register, RR pointer, timeout counter and sticky error.
  always_ff @(posedge clock_a or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      req_q   <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // Clear first so a timeout set further down on the same edge takes priority.
      if (err_clr_i) err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_any) begin
            data_q  <= words[grant_idx];
            src_q   <= grant_idx;
            req_q   <= 1'b1;
            ptr_q   <= rr_idx(grant_idx, 1);
            cnt_q   <= '0;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (ack_s || to_fire) begin
            // On timeout the word is abandoned; the receiver may still see it.
            if (!ack_s) err_q <= 1'b1;
            req_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_RELEASE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (!ack_s) begin
            state_q <= ST_IDLE;
          end else begin
            // Ack stuck high: flag once, keep waiting for it to drop.
            if (to_fire) err_q <= 1'b1;
            if (cnt_q != TO_MAX) cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign xfer_req_o    = req_q;
  assign xfer_data_o   = data_q;
  assign xfer_src_o    = src_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign timeout_err_o = err_q;
endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// Directed + randomised bench for cdc_xfer_arbiter: a clock_b receiver model acks the
// main instance; a second instance with TIMEOUT=8 has its ack driven directly.
`timescale 1ns/1ps
module tb_cdc_xfer_arbiter;
  logic clock_a = 1'b0, clock_b = 1'b0, rst_n = 1'b0;
  int   clkb_half = 7;
  always #5 clock_a = ~clock_a;
  always #(clkb_half) clock_b = ~clock_b;

  // main instance
  logic [3:0]       rvalid = '0;
  logic [3:0][7:0]  rdata  = '0;
  logic [3:0]       ready;
  logic             xreq, busy, terr, ack_b;
  logic [7:0]       xdata;
  logic [1:0]       xsrc;
  logic             clr = 1'b0;

  // timeout instance
  logic [3:0]       tvalid = '0;
  logic [3:0][7:0]  tdata  = '0;
  logic [3:0]       tready;
  logic             treq, tbusy, terr8;
  logic [7:0]       txdata;
  logic [1:0]       txsrc;
  logic             tack = 1'b0, tclr = 1'b0;

  cdc_xfer_arbiter #(.NUM_REQ(4), .DATA_W(8), .SYNC_STAGES(2), .TIMEOUT(64)) dut (
    .clock_a(clock_a), .rst_n(rst_n), .req_valid_i(rvalid), .req_data_i(rdata),
    .req_ready_o(ready), .xfer_req_o(xreq), .xfer_data_o(xdata), .xfer_src_o(xsrc),
    .xfer_ack_i(ack_b), .busy_o(busy), .timeout_err_o(terr), .err_clr_i(clr));

  cdc_xfer_arbiter #(.NUM_REQ(4), .DATA_W(8), .SYNC_STAGES(2), .TIMEOUT(8)) dut_to (
    .clock_a(clock_a), .rst_n(rst_n), .req_valid_i(tvalid), .req_data_i(tdata),
    .req_ready_o(tready), .xfer_req_o(treq), .xfer_data_o(txdata), .xfer_src_o(txsrc),
    .xfer_ack_i(tack), .busy_o(tbusy), .timeout_err_o(terr8), .err_clr_i(tclr));

  int n_chk = 0, n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // clock_b receiver: 2-flop req sync, capture on first synced high, 4-phase ack.
  logic rs1, rs2;
  always @(posedge clock_b or negedge rst_n) begin
    if (!rst_n) begin
      rs1 <= 1'b0; rs2 <= 1'b0; ack_b <= 1'b0;
    end else begin
      rs1 <= xreq;
      rs2 <= rs1;
      if (rs2 && !ack_b) begin
        rx_q.push_back(xdata);
        ack_b <= 1'b1;
      end else if (!rs2) begin
        ack_b <= 1'b0;
      end
    end
  end

  function automatic int mgrant(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
    return 0;
  endfunction

  // Reference round-robin model and hold checks, sampled mid-cycle.
  int         mptr = 0, cur_src = 0;
  logic [7:0] cur_word = '0;
  always @(negedge clock_a) begin
    if (!rst_n) begin
      mptr <= 0;
    end else if (!busy) begin
      if (|rvalid) begin
        chk("grant", ready, 32'(4'b0001 << mgrant(rvalid, mptr)));
        cur_src  <= mgrant(rvalid, mptr);
        cur_word <= rdata[mgrant(rvalid, mptr)];
        exp_q.push_back(rdata[mgrant(rvalid, mptr)]);
        mptr     <= (mgrant(rvalid, mptr) + 1) % 4;
      end else begin
        chk("ready_idle", ready, 0);
      end
    end else begin
      chk("ready_busy", ready, 0);
      if (xreq) begin
        chk("hold_data", xdata, cur_word);
        chk("hold_src", xsrc, cur_src);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock_a);
    #1;
  endtask

  // Bounded wait on busy (sel=0) or xfer_req (sel=1).
  task automatic wait_for(input string tag, input int sel, input logic val);
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (((sel == 0) ? busy : xreq) == val) return;
    end
    chk(tag, (sel == 0) ? busy : xreq, val);
  endtask

  task automatic drain(input string tag);
    wait_for({tag, "_idle"}, 0, 1'b0);
    chk({tag, "_count"}, rx_q.size(), exp_q.size());
    while (exp_q.size() > 0 && rx_q.size() > 0)
      chk({tag, "_word"}, rx_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    rx_q.delete();
  endtask

  initial begin
    int exp_src[5] = '{0, 1, 2, 3, 0};
    int half_tab[6] = '{2, 3, 5, 8, 12, 15};

    // reset state
    #12;
    chk("rst_req", xreq, 0);   chk("rst_busy", busy, 0);
    chk("rst_data", xdata, 0); chk("rst_src", xsrc, 0);
    chk("rst_err", terr, 0);   chk("rst_ready", ready, 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // single requester 2
    rdata = {8'h44, 8'hA5, 8'h22, 8'h11};
    rvalid = 4'b0100;
    #1 chk("t1_ready", ready, 4'b0100);
    tick(1);
    chk("t1_data", xdata, 8'hA5); chk("t1_src", xsrc, 2);
    chk("t1_req", xreq, 1);       chk("t1_busy", busy, 1);
    rvalid = 4'b0000;
    wait_for("t1_reqfall", 1, 1'b0);
    chk("t1_busy_rel", busy, 1);
    wait_for("t1_idle", 0, 1'b0);
    chk("t1_data_held", xdata, 8'hA5);
    drain("t1");

    // wrap from ptr=3
    rdata = {8'h00, 8'h00, 8'hC1, 8'hC0};
    rvalid = 4'b0011;
    #1 chk("t3_ready0", ready, 4'b0001);
    wait_for("t3_acc0", 0, 1'b1);
    chk("t3_src0", xsrc, 0); chk("t3_data0", xdata, 8'hC0);
    wait_for("t3_idle0", 0, 1'b0);
    chk("t3_ready1", ready, 4'b0010);
    wait_for("t3_acc1", 0, 1'b1);
    chk("t3_src1", xsrc, 1); chk("t3_data1", xdata, 8'hC1);
    rvalid = 4'b0000;
    wait_for("t3_idle1", 0, 1'b0);
    rvalid = 4'b1111;
    #1 chk("t3_ptr2", ready, 4'b0100);
    rvalid = 4'b0000;
    drain("t3");

    // reset mid-handshake
    rdata = {8'h00, 8'h5A, 8'h00, 8'h00};
    rvalid = 4'b0100;
    wait_for("t5_acc", 0, 1'b1);
    rvalid = 4'b0000;
    tick(1);
    chk("t5_req_pre", xreq, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_req", xreq, 0); chk("t5_busy", busy, 0);
    chk("t5_data", xdata, 0); chk("t5_src", xsrc, 0);
    exp_q.delete();
    rx_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // all requesters held: 0,1,2,3,0
    rdata = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    rvalid = 4'b1111;
    #1 chk("t2_ready", ready, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      wait_for("t2_acc", 0, 1'b1);
      chk("t2_src", xsrc, exp_src[i]);
      chk("t2_data", xdata, 8'hD0 + 8'(exp_src[i]));
      wait_for("t2_idle", 0, 1'b0);
    end
    rvalid = 4'b0000;
    drain("t2");

    // timeout instance, TIMEOUT=8
    tick(1);
    tdata = {8'h00, 8'h00, 8'h00, 8'h77};
    tvalid = 4'b0001;
    tick(1);
    chk("t4_req", treq, 1); chk("t4_busy", tbusy, 1); chk("t4_data", txdata, 8'h77);
    tvalid = 4'b0000;
    tick(7);
    chk("t4_req_8th", treq, 1); chk("t4_err_pre", terr8, 0);
    tick(1);
    chk("t4_req_drop", treq, 0); chk("t4_err_set", terr8, 1); chk("t4_rel", tbusy, 1);
    tick(1);
    chk("t4_idle", tbusy, 0); chk("t4_err_sticky", terr8, 1);
    tclr = 1'b1;
    tick(1);
    chk("t4_clr", terr8, 0);
    tclr = 1'b0;
    tvalid = 4'b0001;
    tick(1);
    chk("t4_req2", treq, 1);
    tvalid = 4'b0000;
    tick(7);
    chk("t4_req2_8th", treq, 1); chk("t4_err2_pre", terr8, 0);
    tclr = 1'b1;
    tick(1);
    chk("t4_set_wins", terr8, 1); chk("t4_req2_drop", treq, 0);
    tclr = 1'b0;
    tick(1);
    chk("t4_idle2", tbusy, 0);
    // ack stuck high: timeout in RELEASE
    tclr = 1'b1;
    tack = 1'b1;
    tick(1);
    chk("t4_clr2", terr8, 0);
    tclr = 1'b0;
    tvalid = 4'b0001;
    tick(1);
    chk("t4_req3", treq, 1);
    tvalid = 4'b0000;
    tick(1);
    chk("t4_ack_rel", treq, 0); chk("t4_ack_busy", tbusy, 1);
    tick(7);
    chk("t4_rel_pre", terr8, 0); chk("t4_rel_busy", tbusy, 1);
    tick(1);
    chk("t4_rel_err", terr8, 1); chk("t4_rel_stay", tbusy, 1);
    tack = 1'b0;
    tick(2);
    chk("t4_rel_wait", tbusy, 1);
    tick(1);
    chk("t4_rel_idle", tbusy, 0);

    // random traffic across clock_b ratios
    foreach (half_tab[p]) begin
      clkb_half = half_tab[p];
      for (int c = 0; c < 300; c++) begin
        rvalid = 4'($urandom_range(0, 15));
        for (int i = 0; i < 4; i++) rdata[i] = 8'($urandom);
        tick(1);
      end
      rvalid = 4'b0000;
      drain("t6");
    end
    chk("no_timeout", terr, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
